// File: rtl/encoder.sv
// Rate-1/2 K=7 convolutional encoder (133/171 octal) with 2/3 and 3/4 puncturing selected per beat.
// Latency: 1 cycle from input handshake to registered output; full throughput of 1 beat/cycle.
// Backpressure: single output register; s_axis_tready drops only while it is full and m_axis_tready is low.
module encoder #(
    parameter int WIDTH = 24
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [3:0]           s_axis_tuser,
    input  logic                 s_axis_tlast,
    output logic [2*WIDTH-1:0]   m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast
);

    localparam int OW  = 2 * WIDTH;
    localparam int NG2 = WIDTH / 2;   // rate 2/3 puncture groups per beat
    localparam int NG3 = WIDTH / 3;   // rate 3/4 puncture groups per beat

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_2_3 = 2'd1,
        RATE_3_4 = 2'd2
    } rate_t;

    // r_sr[0] holds the most recent input bit (d1), r_sr[5] the oldest (d6).
    logic [5:0]        r_sr;
    logic [OW-1:0]     r_dat;
    logic              r_vld;
    logic              r_last;

    logic              w_accept;
    rate_t             w_rate;
    logic [WIDTH+5:0]  w_seq;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [5:0]        w_sr_nxt;
    logic [OW-1:0]     w_p12;
    logic [OW-1:0]     w_p23;
    logic [OW-1:0]     w_p34;
    logic [OW-1:0]     w_coded;

    // The skid-free handshake: accept whenever the output slot is empty or being drained.
    assign s_axis_tready = aresetn & (~r_vld | m_axis_tready);
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata  = r_dat;
    assign m_axis_tvalid = r_vld;
    assign m_axis_tlast  = r_last;

    // Map the 802.11a RATE field to a puncturing mode; unknown codes fall back to 1/2.
    always_comb begin
        w_rate = RATE_1_2;
        case (s_axis_tuser)
            4'b1011, 4'b1010, 4'b1001: w_rate = RATE_1_2;
            4'b1000:                   w_rate = RATE_2_3;
            4'b1111, 4'b1110,
            4'b1101, 4'b1100:          w_rate = RATE_3_4;
            default:                   w_rate = RATE_1_2;
        endcase
    end

    // Lay the six history bits and the beat out as one time-ordered bit sequence.
    // w_seq[k+6] is x[k]; w_seq[k+6-i] is the input delayed by i bits.
    always_comb begin
        w_seq = '0;
        for (int i = 0; i < 6; i++) begin
            w_seq[5-i] = r_sr[i];
        end
        w_seq[WIDTH+5:6] = s_axis_tdata;
    end

    // Mother code outputs for every bit of the beat (g0 taps 0,2,3,5,6; g1 taps 0,1,2,3,6).
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_a[k] = w_seq[k+6] ^ w_seq[k+4] ^ w_seq[k+3] ^ w_seq[k+1] ^ w_seq[k];
            w_b[k] = w_seq[k+6] ^ w_seq[k+5] ^ w_seq[k+4] ^ w_seq[k+3] ^ w_seq[k];
        end
    end

    // Encoder history after this beat: the last six input bits, newest in bit 0.
    always_comb begin
        w_sr_nxt = '0;
        for (int i = 0; i < 6; i++) begin
            w_sr_nxt[i] = s_axis_tdata[WIDTH-1-i];
        end
    end

    // Build all three punctured layouts; each restarts its pattern at bit 0 of the beat.
    always_comb begin
        w_p12 = '0;
        w_p23 = '0;
        w_p34 = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_p12[2*k]   = w_a[k];
            w_p12[2*k+1] = w_b[k];
        end
        // 2/3: keep A0,B0,A1 out of every two input bits.
        for (int g = 0; g < NG2; g++) begin
            w_p23[3*g]   = w_a[2*g];
            w_p23[3*g+1] = w_b[2*g];
            w_p23[3*g+2] = w_a[2*g+1];
        end
        // 3/4: keep A0,B0,A1,B2 out of every three input bits.
        for (int g = 0; g < NG3; g++) begin
            w_p34[4*g]   = w_a[3*g];
            w_p34[4*g+1] = w_b[3*g];
            w_p34[4*g+2] = w_a[3*g+1];
            w_p34[4*g+3] = w_b[3*g+2];
        end
    end

    // Select the layout for this beat's rate.
    always_comb begin
        w_coded = w_p12;
        case (w_rate)
            RATE_2_3: w_coded = w_p23;
            RATE_3_4: w_coded = w_p34;
            default:  w_coded = w_p12;
        endcase
    end

    // Output register: load on accept, empty on a drain with nothing new behind it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_vld  <= 1'b0;
            r_dat  <= '0;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_vld  <= 1'b1;
            r_dat  <= w_coded;
            r_last <= s_axis_tlast;
        end else if (m_axis_tready) begin
            r_vld  <= 1'b0;
        end
    end

    // Encoder state carries across beats and restarts from zero after a packet's last beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sr <= '0;
        end else if (w_accept) begin
            r_sr <= s_axis_tlast ? 6'd0 : w_sr_nxt;
        end
    end

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for the punctured convolutional encoder.
// Driver pushes expected beats at each input handshake; a negedge monitor pops and compares.
// Output stability is checked whenever the DUT holds a beat under backpressure.
module tb_encoder;

    localparam int W  = 24;
    localparam int OW = 48;

    localparam logic [OW-1:0] K12 = 48'h000e7c40858b;
    localparam logic [OW-1:0] K34 = 48'h0000009c0063;
    localparam logic [OW-1:0] K23 = 48'h000006f20143;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [3:0]    s_axis_tuser;
    logic          s_axis_tlast;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    always #5 aclk = ~aclk;

    encoder #(.WIDTH(W)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    typedef struct packed {
        logic [OW-1:0] dat;
        logic          last;
    } exp_t;

    exp_t        q[$];
    logic [5:0]  m_hist;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_push   = 0;
    int          n_out    = 0;
    int          cyc      = 0;
    bit          hold_v   = 0;
    logic [OW:0] hold_d;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Bit-serial reference: 7-bit window (bit 0 = current input, bit i = delay i)
    // ANDed with the generator tap masks, then punctured by walking a keep table.
    function automatic logic [OW-1:0] model(input logic [W-1:0] x, input logic [3:0] code,
                                            input logic [5:0] hin, output logic [5:0] hout);
        logic [6:0]    win;
        logic [5:0]    h;
        logic [2:0]    keep_a;
        logic [2:0]    keep_b;
        logic [OW-1:0] o;
        logic          a;
        logic          b;
        int            period;
        int            pos;
        case (code)
            4'b1000: begin period = 2; keep_a = 3'b011; keep_b = 3'b001; end
            4'b1111, 4'b1110, 4'b1101, 4'b1100:
                     begin period = 3; keep_a = 3'b011; keep_b = 3'b101; end
            default: begin period = 1; keep_a = 3'b001; keep_b = 3'b001; end
        endcase
        h   = hin;
        o   = '0;
        pos = 0;
        for (int k = 0; k < W; k++) begin
            win = {h, x[k]};
            a   = ^(win & 7'b1101101);   // taps 0,2,3,5,6 (133 octal)
            b   = ^(win & 7'b1001111);   // taps 0,1,2,3,6 (171 octal)
            if (keep_a[k % period]) begin o[pos] = a; pos++; end
            if (keep_b[k % period]) begin o[pos] = b; pos++; end
            h = {h[4:0], x[k]};
        end
        hout = h;
        return o;
    endfunction

    // Present one beat; optionally raise m_axis_tready after rel_after stalled cycles.
    // If use_exp is set the hand-computed value is expected instead of the model's.
    task automatic send(input logic [W-1:0] d, input logic [3:0] u, input logic l,
                        input bit use_exp, input logic [OW-1:0] ev, input int rel_after);
        logic [OW-1:0] mv;
        logic [5:0]    hn;
        bit            acc;
        int            waited;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        acc    = 0;
        waited = 0;
        while (!acc && waited < 50) begin
            @(negedge aclk);
            if (rel_after >= 0 && waited < rel_after) check("bp_s_tready_low", 64'(s_axis_tready), 64'd0);
            acc = s_axis_tready;
            @(posedge aclk);
            #1;
            waited++;
            if (rel_after >= 0 && waited == rel_after) m_axis_tready = 1'b1;
        end
        s_axis_tvalid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL send_timeout: beat %h never accepted within %0d cycles", d, waited);
        end else begin
            mv     = model(d, u, m_hist, hn);
            m_hist = l ? 6'd0 : hn;
            q.push_back({use_exp ? ev : mv, l});
            n_push++;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        m_axis_tready = 1'b1;
        while (q.size() != 0 && t < 40) begin
            @(posedge aclk);
            #1;
            t++;
        end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d beats still outstanding, expected 0", q.size());
        end
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        m_hist        = 6'd0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    // Monitor: compare every delivered beat against the scoreboard head, and
    // require a stalled beat to stay unchanged until it is taken.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && m_axis_tvalid) begin
                if (hold_v) check("hold_stable", 64'({m_axis_tlast, m_axis_tdata}), 64'(hold_d));
                if (m_axis_tready) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got %h, expected no beat", m_axis_tdata);
                    end else begin
                        e = q.pop_front();
                        check("beat_tdata", 64'(m_axis_tdata), 64'(e.dat));
                        check("beat_tlast", 64'(m_axis_tlast), 64'(e.last));
                        n_out++;
                    end
                    hold_v = 0;
                end else begin
                    hold_v = 1;
                    hold_d = {m_axis_tlast, m_axis_tdata};
                end
            end else begin
                hold_v = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [W-1:0] words[10];
        logic [W-1:0] mix_d[6];
        logic [3:0]   mix_u[6];
        words = '{24'h3b5a71, 24'h9c04e2, 24'h5ff00d, 24'h81a3c6, 24'h2e7b19,
                  24'hd40c58, 24'h06e9a3, 24'hb71f44, 24'h6a2d8e, 24'hf3510b};
        mix_d = '{24'h1c2d3e, 24'ha5a5a5, 24'h7e81ff, 24'h00ff00, 24'h924924, 24'hc3c3c3};
        mix_u = '{4'b1010, 4'b1101, 4'b1100, 4'b0000, 4'b1001, 4'b1110};

        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = 4'd0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        m_hist        = 6'd0;

        // Reset state
        #12;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
        check("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("idle_s_tready", 64'(s_axis_tready), 64'd1);

        // Rate 1/2, downstream ready before the beat arrives
        m_axis_tready = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        send(24'h000c8d, 4'b1011, 1'b0, 1, K12, -1);
        drain();

        // Rate 1/2, valid and ready raised together
        do_reset();
        m_axis_tready = 1'b0;
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        send(24'h000c8d, 4'b1011, 1'b0, 1, K12, -1);
        drain();

        // Rate 1/2, beat waits on a full output slot before being taken
        do_reset();
        m_axis_tready = 1'b0;
        send(24'h123456, 4'b1011, 1'b1, 0, '0, -1);
        send(24'h000c8d, 4'b1011, 1'b0, 1, K12, 3);
        drain();

        // Rate 3/4 from reset, then a back-to-back stream carrying state
        do_reset();
        m_axis_tready = 1'b1;
        send(24'h000c8d, 4'b1111, 1'b0, 1, K34, -1);
        t0 = cyc;
        for (int i = 0; i < 10; i++) send(words[i], 4'b1111, 1'b0, 0, '0, -1);
        check("stream34_cycles", 64'(cyc - t0), 64'd10);
        drain();

        // Rate 2/3 from reset
        do_reset();
        send(24'h000c8d, 4'b1000, 1'b0, 1, K23, -1);
        drain();

        // Rate changing beat to beat, including an unassigned code
        for (int i = 0; i < 6; i++) send(mix_d[i], mix_u[i], 1'b0, 0, '0, -1);
        drain();

        // Backpressure: stalled five cycles, then streaming at full rate
        m_axis_tready = 1'b0;
        send(24'h5a5a5a, 4'b1011, 1'b0, 0, '0, -1);
        send(24'h0f0f0f, 4'b1100, 1'b0, 0, '0, 5);
        t0 = cyc;
        for (int i = 0; i < 4; i++) send(words[i], 4'b1010, 1'b0, 0, '0, -1);
        check("bp_release_cycles", 64'(cyc - t0), 64'd4);
        drain();

        // Packet boundary: tlast beat uses prior state, next beat starts from zero
        send(24'habcdef, 4'b1011, 1'b0, 0, '0, -1);
        send(24'h000c8d, 4'b1011, 1'b1, 0, '0, -1);
        send(24'h000c8d, 4'b1011, 1'b0, 1, K12, -1);
        drain();

        // Reset while a beat is held in the output register
        m_axis_tready = 1'b0;
        send(24'h000c8d, 4'b1011, 1'b0, 0, '0, -1);
        #2;
        check("pre_rst_m_tvalid", 64'(m_axis_tvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        check("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_m_tdata",  64'(m_axis_tdata),  64'd0);
        check("midrst_m_tlast",  64'(m_axis_tlast),  64'd0);
        check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        n_push = n_push - q.size();
        q.delete();
        m_hist = 6'd0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        m_axis_tready = 1'b1;
        send(24'h000c8d, 4'b1011, 1'b0, 1, K12, -1);
        drain();

        repeat (2) begin @(posedge aclk); #1; end
        check("beats_out_vs_in", 64'(n_out), 64'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/encoder.md
Name: encoder

Overview:
- IEEE 802.11a convolutional encoder: constraint length 7, generators g0=133 (octal) and g1=171 (octal), with per-rate puncturing.
- Takes 24-bit scrambled data beats on an AXI4-Stream slave and emits coded beats of up to 48 bits on an AXI4-Stream master.
- Sits between the scrambler and the interleaver in the transmit chain.
- The code rate for each beat is selected by the 802.11a RATE code carried on s_axis_tuser.

Parameters:
- WIDTH, 24, input beat width in bits. Must be divisible by 6; the output width is 2*WIDTH.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  WIDTH  uncoded bits; bit 0 is the first in time.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when tvalid and tready are both high.
- s_axis_tuser  in  4  RATE code for this beat.
- s_axis_tlast  in  1  last beat of the packet.
- m_axis_tdata  out  2*WIDTH  coded bits, LSB first; unused upper bits are 0.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  copy of s_axis_tlast for this beat.

Behaviour:
- Reset (aresetn low, asynchronous):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - 6-bit shift register cleared to 0.
  - s_axis_tready=0 while aresetn is low.
- Handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - On input accept, the coded result is registered into m_axis_tdata and m_axis_tlast, and m_axis_tvalid is set on the next edge. Latency is 1 cycle.
  - m_axis_tvalid clears on an output handshake with no new input.
  - Output is held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - Full throughput: 1 beat/cycle when m_axis_tready stays high.
  - tvalid-before-tready, tready-before-tvalid and simultaneous assertion must all produce identical results.
- Encoding, per input bit x[k], k=0..WIDTH-1, in time order:
  - d[i] is the input delayed by i bits; the shift register carries across beats.
  - A[k] = x[k]^d[2]^d[3]^d[5]^d[6].
  - B[k] = x[k]^d[1]^d[2]^d[3]^d[6].
  - The mother sequence is A0,B0,A1,B1,...
- Puncturing: patterns restart at bit 0 of every beat; packed contiguously from bit 0.
  - Rate 1/2: all bits kept; out[2k]=A[k], out[2k+1]=B[k]; 48 bits.
  - Rate 2/3: per 2 inputs emit A0,B0,A1 (B1 dropped); 36 bits in [35:0].
  - Rate 3/4: per 3 inputs emit A0,B0,A1,B2 (B1 and A2 dropped); 32 bits in [31:0].
- RATE code decode (s_axis_tuser):
  - 1011 (6M), 1010 (12M), 1001 (24M) select rate 1/2.
  - 1000 (48M) selects rate 2/3.
  - 1111 (9M), 1110 (18M), 1101 (36M), 1100 (54M) select rate 3/4.
  - Any other code is treated as rate 1/2.
  - tuser is sampled per accepted beat, so the rate may change beat to beat.
- Packet boundary:
  - After accepting a beat with s_axis_tlast=1, the shift register is cleared to 0 for the next beat.
  - The tlast beat itself encodes with the prior state.
- Reset mid-operation discards any pending output beat immediately (m_axis_tvalid drops asynchronously).
- No internal buffering beyond the single output register.

Test Plan:
- Rate 1/2 from reset: tuser=1011, tdata=24'h000c8d, presented in all three handshake orderings -> m_axis_tdata=48'h000e7c40858b each time.
- Rate 3/4 from reset: tuser=1111, tdata=24'h000c8d -> m_axis_tdata=48'h0000009c0063. Then stream 10 consecutive scrambled 802.11a words back-to-back with state carried over -> each beat matches the standard 3/4 coded reference.
- Rate 2/3 from reset: tuser=1000, tdata=24'h000c8d -> m_axis_tdata=48'h000006f20143.
- Backpressure: hold m_axis_tready=0 for 5 cycles with input valid -> s_axis_tready=0, output held stable, no beat lost or duplicated; releasing tready gives 1 beat/cycle.
- tlast: send 24'h000c8d with tlast=1, then 24'h000c8d at rate 1/2 -> second output again 48'h000e7c40858b, with m_axis_tlast=1 on the first beat only.
- Reset mid-stream: assert aresetn low while m_axis_tvalid=1 -> outputs go to 0 immediately; the first beat after release encodes from zero state.
